// File: rtl/mem_stage_lsu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_stage_lsu_pkg: shared encodings for the MEM-stage load/store   |
// | unit. Revision 1.0                                                 |
// +--------------------------------------------------------------------+
package mem_stage_lsu_pkg;

  localparam int c_CST_ST    = 5;
  localparam int c_CST_LD    = 1;
  localparam int c_CST_SZ_HI = 4;
  localparam int c_CST_SZ_LO = 2;

  typedef enum logic [2:0] {
    SZ_B  = 3'b000,
    SZ_H  = 3'b001,
    SZ_W  = 3'b010,
    SZ_D  = 3'b011,
    SZ_BU = 3'b100,
    SZ_HU = 3'b101,
    SZ_WU = 3'b110
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // The low two funct3 bits are log2 of the access size in bytes.
  function automatic logic [1:0] size_log2(input logic [2:0] i_size);
    return i_size[1:0];
  endfunction

  function automatic logic [7:0] lane_mask(input logic [2:0] i_size);
    logic [7:0] w_m;
    case (i_size[1:0])
      2'd0:    w_m = 8'h01;
      2'd1:    w_m = 8'h03;
      2'd2:    w_m = 8'h0F;
      default: w_m = 8'hFF;
    endcase
    return w_m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_stage_lsu_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_stage_lsu_if: data-memory req/ack bus between the LSU and      |
// | memory. Revision 1.0                                               |
// +--------------------------------------------------------------------+
interface mem_stage_lsu_if #(
  parameter int XLEN = 64
);
  localparam int c_NB = XLEN / 8;

  logic              req;
  logic              we;
  logic [XLEN-1:0]   addr;
  logic [XLEN-1:0]   wdata;
  logic [c_NB-1:0]   be;
  logic [XLEN-1:0]   rdata;
  logic              ack;

  modport master (
    output req, we, addr, wdata, be,
    input  rdata, ack
  );

  modport slave (
    input  req, we, addr, wdata, be,
    output rdata, ack
  );
endinterface
`default_nettype wire

// File: rtl/mem_stage_lsu_align.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_stage_lsu_align: store lane shift/byte enables, load extract   |
// | and extension, misalignment detect. Revision 1.0                   |
// +--------------------------------------------------------------------+
module mem_stage_lsu_align
  import mem_stage_lsu_pkg::*;
#(
  parameter  int XLEN = 64,
  localparam int NB   = XLEN / 8,
  localparam int OFFW = $clog2(XLEN / 8)
) (
  input  logic [2:0]      i_size,
  input  logic [OFFW-1:0] i_off,
  input  logic [XLEN-1:0] i_st_data,
  input  logic [XLEN-1:0] i_rdata,
  output logic [XLEN-1:0] o_wdata,
  output logic [NB-1:0]   o_be,
  output logic [XLEN-1:0] o_ld_data,
  output logic            o_misalign
);

  logic [7:0]      w_mask8;
  logic [3:0]      w_span;
  logic [OFFW-1:0] w_align;
  logic [XLEN-1:0] w_shift;
  logic            w_too_wide;

  always_comb begin
    w_mask8   = lane_mask(i_size);
    o_be      = w_mask8[NB-1:0] << i_off;
    o_wdata   = i_st_data << {i_off, 3'b000};
    w_shift   = i_rdata >> {i_off, 3'b000};

    case (size_e'(i_size))
      SZ_B:    o_ld_data = XLEN'($signed(w_shift[7:0]));
      SZ_H:    o_ld_data = XLEN'($signed(w_shift[15:0]));
      SZ_W:    o_ld_data = XLEN'($signed(w_shift[31:0]));
      SZ_BU:   o_ld_data = XLEN'(w_shift[7:0]);
      SZ_HU:   o_ld_data = XLEN'(w_shift[15:0]);
      SZ_WU:   o_ld_data = XLEN'(w_shift[31:0]);
      default: o_ld_data = w_shift;
    endcase

    // Doubleword and unsigned-word loads do not exist on a 32-bit datapath;
    // funct3 111 is unassigned and is rejected the same way.
    w_too_wide = (i_size == 3'b111) ||
                 ((XLEN == 32) && ((i_size == SZ_D) || (i_size == SZ_WU)));
    w_span     = (4'd1 << size_log2(i_size)) - 4'd1;
    w_align    = OFFW'(w_span);
    o_misalign = ((i_off & w_align) != '0) || w_too_wide;
  end

endmodule
`default_nettype wire

// File: rtl/mem_stage_lsu.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_stage_lsu: MEM pipeline stage with variable-latency data       |
// | memory handshake, stall control and WB register bank. Rev 1.0      |
// +--------------------------------------------------------------------+
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int ILEN  = 32,
  parameter int CST_W = 19
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_mem_v,
  input  logic [ILEN-1:0]  i_mem_ir,
  input  logic [CST_W-1:0] i_mem_cst,
  input  logic [XLEN-1:0]  i_mem_res,
  input  logic [XLEN-1:0]  i_mem_address,
  input  logic [XLEN-1:0]  i_mem_npc,
  input  logic [XLEN-1:0]  i_mem_target_address,
  input  logic             i_mem_pc_mux,
  input  logic             i_de_context_switch,
  mem_stage_lsu_if.master  dm,
  output logic             o_mem_stall,
  output logic [4:0]       o_mem_dr,
  output logic             o_wb_v,
  output logic             o_wb_pc_mux,
  output logic             o_wb_misalign,
  output logic [CST_W-1:0] o_wb_cst,
  output logic [ILEN-1:0]  o_wb_ir,
  output logic [XLEN-1:0]  o_wb_res,
  output logic [XLEN-1:0]  o_wb_npc,
  output logic [XLEN-1:0]  o_wb_target_address
);

  localparam int c_NB   = XLEN / 8;
  localparam int c_OFFW = $clog2(c_NB);

  state_e            r_state;
  state_e            w_state_nxt;
  logic              w_is_st;
  logic              w_is_ld;
  logic              w_acc;
  logic              w_misalign;
  logic              w_go;
  logic              w_req;
  logic              w_stall;
  logic              w_wb_v_nxt;
  logic [2:0]        w_size;
  logic [c_OFFW-1:0] w_off;
  logic [XLEN-1:0]   w_wdata;
  logic [XLEN-1:0]   w_ld_data;
  logic [c_NB-1:0]   w_be;

  logic              r_wb_v;
  logic              r_wb_pc_mux;
  logic              r_wb_misalign;
  logic [CST_W-1:0]  r_wb_cst;
  logic [ILEN-1:0]   r_wb_ir;
  logic [XLEN-1:0]   r_wb_res;
  logic [XLEN-1:0]   r_wb_npc;
  logic [XLEN-1:0]   r_wb_target_address;

  assign w_is_st = i_mem_cst[c_CST_ST];
  assign w_is_ld = i_mem_cst[c_CST_LD];
  assign w_size  = i_mem_cst[c_CST_SZ_HI:c_CST_SZ_LO];
  assign w_off   = i_mem_address[c_OFFW-1:0];
  assign w_acc   = i_mem_v & (w_is_st | w_is_ld);
  assign w_go    = w_acc & ~w_misalign;

  mem_stage_lsu_align #(
    .XLEN (XLEN)
  ) u_align (
    .i_size     (w_size),
    .i_off      (w_off),
    .i_st_data  (i_mem_res),
    .i_rdata    (dm.rdata),
    .o_wdata    (w_wdata),
    .o_be       (w_be),
    .o_ld_data  (w_ld_data),
    .o_misalign (w_misalign)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    w_stall     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // A flushed access is dropped before it reaches the memory.
        if (w_go && !i_de_context_switch) begin
          w_req = 1'b1;
          if (!dm.ack) begin
            w_stall     = 1'b1;
            w_state_nxt = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        w_req = 1'b1;
        if (dm.ack) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_stall = 1'b1;
          if (i_de_context_switch) begin
            w_state_nxt = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        // The issued access must still complete; its result is thrown away.
        w_req = 1'b1;
        if (dm.ack) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_stall = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign w_wb_v_nxt = i_mem_v & ~i_de_context_switch & ~w_stall &
                      (r_state != ST_DRAIN);

  // Reset gating keeps REQ/STALL low for the whole reset window, even while
  // upstream is still presenting the interrupted access.
  assign dm.req      = w_req & rst_n;
  assign o_mem_stall = w_stall & rst_n;
  assign dm.we       = w_is_st;
  assign dm.addr     = {i_mem_address[XLEN-1:c_OFFW], {c_OFFW{1'b0}}};
  assign dm.wdata    = w_wdata;
  assign dm.be       = w_be;
  assign o_mem_dr    = i_mem_ir[11:7];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb_v              <= 1'b0;
      r_wb_pc_mux         <= 1'b0;
      r_wb_misalign       <= 1'b0;
      r_wb_cst            <= '0;
      r_wb_ir             <= '0;
      r_wb_res            <= '0;
      r_wb_npc            <= '0;
      r_wb_target_address <= '0;
    end else begin
      r_wb_v <= w_wb_v_nxt;
      if (!w_stall) begin
        r_wb_pc_mux         <= i_mem_pc_mux;
        r_wb_misalign       <= w_acc & w_misalign;
        r_wb_cst            <= i_mem_cst;
        r_wb_ir             <= i_mem_ir;
        r_wb_res            <= (w_go && w_is_ld && !w_is_st) ? w_ld_data : i_mem_res;
        r_wb_npc            <= i_mem_npc;
        r_wb_target_address <= i_mem_target_address;
      end
    end
  end

  assign o_wb_v              = r_wb_v;
  assign o_wb_pc_mux         = r_wb_pc_mux;
  assign o_wb_misalign       = r_wb_misalign;
  assign o_wb_cst            = r_wb_cst;
  assign o_wb_ir             = r_wb_ir;
  assign o_wb_res            = r_wb_res;
  assign o_wb_npc            = r_wb_npc;
  assign o_wb_target_address = r_wb_target_address;

endmodule
`default_nettype wire
